// File: rtl/set_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : set_job_scheduler
// Description : Round-robin sharing of one SET circle-membership counter among
//               N_REQ requesters. Holds the job operands stable on the SET
//               port, returns the result to the granted requester and aborts
//               any job SET fails to answer within TIMEOUT cycles.
// Revision    : 1.0  initial release
// ============================================================================
module set_job_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [24*N_REQ-1:0]   req_central_i,
    input  logic [12*N_REQ-1:0]   req_radius_i,
    input  logic [2*N_REQ-1:0]    req_mode_i,
    output logic [N_REQ-1:0]      rsp_valid_o,
    output logic [7:0]            rsp_candidate_o,
    output logic                  rsp_err_o,
    output logic [15:0]           jobs_done_o,
    output logic                  set_en_o,
    output logic [23:0]           set_central_o,
    output logic [11:0]           set_radius_o,
    output logic [1:0]            set_mode_o,
    input  logic                  set_busy_i,
    input  logic                  set_valid_i,
    input  logic [7:0]            set_candidate_i
);

    localparam int c_PW = $clog2(N_REQ);
    localparam int c_TW = $clog2(TIMEOUT);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic [c_TW-1:0] c_T_LAST   = c_TW'(TIMEOUT - 1);
    localparam logic [c_PW-1:0] c_LAST_IDX = c_PW'(N_REQ - 1);

    logic [1:0]      state_q, state_d;
    logic [c_PW-1:0] ptr_q;
    logic [c_PW-1:0] gnt_q;
    logic [c_TW-1:0] timer_q;
    logic [7:0]      cand_q;
    logic            err_q;
    logic [15:0]     jobs_q;
    logic [23:0]     central_q;
    logic [11:0]     radius_q;
    logic [1:0]      mode_q;

    logic            w_found;
    logic [c_PW-1:0] w_gnt;
    logic            w_take;
    logic            w_wait_done;

    // Round-robin search: first pending requester starting at the pointer.
    always_comb begin : p_arb
        logic [c_PW:0] v_sum;
        v_sum   = '0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_sum = {1'b0, ptr_q} + (c_PW+1)'(k);
            if (v_sum >= (c_PW+1)'(N_REQ)) begin
                v_sum = v_sum - (c_PW+1)'(N_REQ);
            end
            if (!w_found && req_valid_i[v_sum[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = v_sum[c_PW-1:0];
            end
        end
    end

    // Grant only from IDLE while SET is free; reset masks the accept pulse.
    assign w_take      = (state_q == c_ST_IDLE) && w_found && !set_busy_i && !rst;
    // A real answer wins over the watchdog when both occur together.
    assign w_wait_done = set_valid_i || (timer_q == c_T_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (w_take) state_d = c_ST_ISSUE;
            c_ST_ISSUE: state_d = c_ST_WAIT;
            c_ST_WAIT:  if (w_wait_done) state_d = c_ST_RESP;
            c_ST_RESP:  state_d = c_ST_IDLE;
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // Output decode: handshake pulses and the result, zero outside RESP.
    always_comb begin
        req_ready_o     = w_take ? (N_REQ'(1) << w_gnt) : '0;
        set_en_o        = (state_q == c_ST_ISSUE);
        rsp_valid_o     = '0;
        rsp_candidate_o = '0;
        rsp_err_o       = 1'b0;
        if (state_q == c_ST_RESP) begin
            rsp_valid_o     = N_REQ'(1) << gnt_q;
            rsp_candidate_o = cand_q;
            rsp_err_o       = err_q;
        end
    end

    // Job datapath: operand latch, pointer, watchdog timer, result, counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            gnt_q     <= '0;
            timer_q   <= '0;
            cand_q    <= '0;
            err_q     <= 1'b0;
            jobs_q    <= '0;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (w_take) begin
                        central_q <= req_central_i[w_gnt*24 +: 24];
                        radius_q  <= req_radius_i[w_gnt*12 +: 12];
                        mode_q    <= req_mode_i[w_gnt*2 +: 2];
                        gnt_q     <= w_gnt;
                        ptr_q     <= (w_gnt == c_LAST_IDX) ? '0 : w_gnt + c_PW'(1);
                    end
                end
                c_ST_ISSUE: begin
                    timer_q <= '0;
                end
                c_ST_WAIT: begin
                    if (set_valid_i) begin
                        cand_q <= set_candidate_i;
                        err_q  <= 1'b0;
                    end else if (timer_q == c_T_LAST) begin
                        cand_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + c_TW'(1);
                    end
                end
                c_ST_RESP: begin
                    jobs_q <= jobs_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign jobs_done_o   = jobs_q;
    assign set_central_o = central_q;
    assign set_radius_o  = radius_q;
    assign set_mode_o    = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_set_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_job_scheduler
// Description : Directed bench for set_job_scheduler with a behavioural SET
//               stub whose latency is programmable and whose answer is the
//               low byte of the granted central word XOR a key.
// Revision    : 1.0  initial release
// ============================================================================
module tb_set_job_scheduler;

    localparam logic [23:0] c_C0 = 24'h012345;
    localparam logic [23:0] c_C1 = 24'h6789AB;
    localparam logic [23:0] c_C2 = 24'h345678;
    localparam logic [23:0] c_C3 = 24'hFEDCBA;
    localparam logic [11:0] c_R0 = 12'h123;
    localparam logic [11:0] c_R1 = 12'h456;
    localparam logic [11:0] c_R2 = 12'h234;
    localparam logic [11:0] c_R3 = 12'h789;
    localparam logic [1:0]  c_M0 = 2'b00;
    localparam logic [1:0]  c_M1 = 2'b10;
    localparam logic [1:0]  c_M2 = 2'b01;
    localparam logic [1:0]  c_M3 = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'hF;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_candidate;
    logic        rsp_err;
    logic [15:0] jobs_done;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;

    logic        busy_s  = 1'b0;
    logic        valid_s = 1'b0;
    logic [7:0]  cand_s  = 8'h00;
    int          cnt_s   = 0;
    int          stub_lat = 5;
    logic [7:0]  stub_key = 8'h69;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_jobs = 16'd0;

    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // SET stub: answers stub_lat cycles after set_en, busy in between.
    always @(posedge clk) begin
        if (rst) begin
            busy_s  <= 1'b0;
            valid_s <= 1'b0;
            cand_s  <= 8'h00;
            cnt_s   <= 0;
        end else begin
            valid_s <= 1'b0;
            if (set_en) begin
                busy_s <= 1'b1;
                cnt_s  <= stub_lat - 1;
            end else if (busy_s) begin
                if (cnt_s <= 1) begin
                    busy_s  <= 1'b0;
                    valid_s <= 1'b1;
                    cand_s  <= set_central[7:0] ^ stub_key;
                end
                cnt_s <= cnt_s - 1;
            end
        end
    end

    set_job_scheduler #(.N_REQ(4), .TIMEOUT(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_central_i   ({c_C3, c_C2, c_C1, c_C0}),
        .req_radius_i    ({c_R3, c_R2, c_R1, c_R0}),
        .req_mode_i      ({c_M3, c_M2, c_M1, c_M0}),
        .rsp_valid_o     (rsp_valid),
        .rsp_candidate_o (rsp_candidate),
        .rsp_err_o       (rsp_err),
        .jobs_done_o     (jobs_done),
        .set_en_o        (set_en),
        .set_central_o   (set_central),
        .set_radius_o    (set_radius),
        .set_mode_o      (set_mode),
        .set_busy_i      (busy_s),
        .set_valid_i     (valid_s),
        .set_candidate_i (cand_s)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return {24'h0, req_ready, rsp_valid, rsp_candidate, rsp_err, jobs_done,
                set_en, set_central, set_radius, set_mode};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_outputs_zero", all_outs(), 96'h0);
        end
        rst = 1'b0;
        exp_jobs = 16'd0;
    endtask

    // One complete job: accept, issue, response, counter update.
    task automatic job(input string tag, input logic [3:0] exp_rdy,
                       input logic [23:0] ec, input logic [11:0] er, input logic [1:0] em,
                       input logic [7:0] ecand, input logic eerr, input int edly,
                       input logic [3:0] drop, output int t_acc);
        int n;
        int en_cnt;
        n = 0;
        #1;
        while (req_ready === 4'b0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_ready"}, req_ready, exp_rdy);
        t_acc = cyc;
        @(negedge clk); #1;
        chk({tag, "_set_en"}, set_en, 1'b1);
        chk({tag, "_set_ops"}, {set_central, set_radius, set_mode}, {ec, er, em});
        req_valid = req_valid & ~drop;
        en_cnt = 0;
        n = 0;
        @(negedge clk); #1;
        while (rsp_valid === 4'b0 && n < 300) begin
            if (set_en) en_cnt++;
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, exp_rdy);
        chk({tag, "_cand"}, rsp_candidate, ecand);
        chk({tag, "_err"}, rsp_err, eerr);
        chk({tag, "_latency"}, cyc - t_acc, edly);
        chk({tag, "_ops_held"}, {set_central, set_radius, set_mode}, {ec, er, em});
        chk({tag, "_en_once"}, en_cnt, 0);
        chk({tag, "_jobs_in_rsp"}, jobs_done, exp_jobs);
        exp_jobs = exp_jobs + 16'd1;
        @(negedge clk); #1;
        chk({tag, "_jobs"}, jobs_done, exp_jobs);
        chk({tag, "_rsp_clear"}, {rsp_valid, rsp_candidate, rsp_err}, 13'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int t [0:5];
        int ta;
        int n;

        // 1: reset with all requests pending, then requester 0 first.
        do_reset();
        stub_lat = 5;
        job("t1", 4'b0001, c_C0, c_R0, c_M0, 8'h2C, 1'b0, 7, 4'hF, ta);

        // 2: single requester 2, answer 17 after 20 cycles.
        do_reset();
        req_valid = 4'b0100;
        stub_lat = 20;
        job("t2", 4'b0100, c_C2, c_R2, c_M2, 8'd17, 1'b0, 22, 4'b0100, ta);

        // 3: all requesting, round-robin order 0,1,2,3,0,1.
        do_reset();
        req_valid = 4'hF;
        stub_lat = 5;
        job("t3a", 4'b0001, c_C0, c_R0, c_M0, 8'h2C, 1'b0, 7, 4'h0, t[0]);
        job("t3b", 4'b0010, c_C1, c_R1, c_M1, 8'hC2, 1'b0, 7, 4'h0, t[1]);
        job("t3c", 4'b0100, c_C2, c_R2, c_M2, 8'h11, 1'b0, 7, 4'h0, t[2]);
        job("t3d", 4'b1000, c_C3, c_R3, c_M3, 8'hD3, 1'b0, 7, 4'h0, t[3]);
        job("t3e", 4'b0001, c_C0, c_R0, c_M0, 8'h2C, 1'b0, 7, 4'h0, t[4]);
        job("t3f", 4'b0010, c_C1, c_R1, c_M1, 8'hC2, 1'b0, 7, 4'hF, t[5]);
        for (int i = 1; i < 6; i++) chk("t3_interval", t[i] - t[i-1], 8);

        // 4: stub too slow -> watchdog abort 66 cycles after accept.
        req_valid = 4'b0001;
        stub_lat = 80;
        job("t4", 4'b0001, c_C0, c_R0, c_M0, 8'h00, 1'b1, 66, 4'b0001, ta);
        n = 0;
        while (valid_s !== 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t4_late_valid_seen", valid_s, 1'b1);
        repeat (2) begin
            @(negedge clk); #1;
            chk("t4_late_ignored", {rsp_valid, jobs_done}, {4'b0, exp_jobs});
        end
        req_valid = 4'b0010;
        stub_lat = 5;
        job("t4n", 4'b0010, c_C1, c_R1, c_M1, 8'hC2, 1'b0, 7, 4'b0010, ta);

        // 5: answer lands on the terminal timer cycle -> answer wins.
        req_valid = 4'b1000;
        stub_lat = 64;
        job("t5", 4'b1000, c_C3, c_R3, c_M3, 8'hD3, 1'b0, 66, 4'b1000, ta);

        // 6: reset during WAIT drops the job; 1 served before 3.
        req_valid = 4'b1000;
        stub_lat = 30;
        n = 0;
        #1;
        while (req_ready === 4'b0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t6_ready", req_ready, 4'b1000);
        @(negedge clk); #1;
        req_valid = 4'b0000;
        repeat (5) begin
            @(negedge clk); #1;
        end
        rst = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk); #1;
        chk("t6_rst_outputs_zero", all_outs(), 96'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        exp_jobs = 16'd0;
        stub_lat = 5;
        job("t6a", 4'b0010, c_C1, c_R1, c_M1, 8'hC2, 1'b0, 7, 4'b0010, ta);
        job("t6b", 4'b1000, c_C3, c_R3, c_M3, 8'hD3, 1'b0, 7, 4'b1000, ta);

        // 7: pointer moved past 1, then reset brings priority back to 0.
        req_valid = 4'b0010;
        job("t7a", 4'b0010, c_C1, c_R1, c_M1, 8'hC2, 1'b0, 7, 4'b0010, ta);
        do_reset();
        req_valid = 4'b1010;
        job("t7b", 4'b0010, c_C1, c_R1, c_M1, 8'hC2, 1'b0, 7, 4'b1010, ta);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
